// File: rtl/mem_arbiter_if.sv
// Signal bundle between mem_arbiter, its two requesters (CPU, DMA) and the memory port.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  cpu_req;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic                  cpu_ack;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  cpu_stall;

  logic                  dma_req;
  logic                  dma_we;
  logic [ADDR_WIDTH-1:0] dma_addr;
  logic [DATA_WIDTH-1:0] dma_wdata;
  logic                  dma_lock;
  logic                  dma_ack;
  logic [DATA_WIDTH-1:0] dma_rdata;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Arbiter side
  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata, dma_lock,
    input  mem_rdata,
    output cpu_ack, cpu_rdata, cpu_stall,
    output dma_ack, dma_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  // Requester / memory side
  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata, dma_lock,
    output mem_rdata,
    input  cpu_ack, cpu_rdata, cpu_stall,
    input  dma_ack, dma_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// CPU/DMA arbiter and sequencer for the single-port system memory, with DMA burst locking.
// Define ARB_ROUND_ROBIN_EN for round-robin unlocked ties; default build gives ties to DMA.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned MAX_BURST   = 256
) (
  input  logic          clk,
  input  logic          reset_n,
  mem_arbiter_if.master bus
);

  localparam int unsigned WAIT_W  = 2;
  localparam int unsigned BURST_W = 9;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_e;

  state_e                state_q;
  logic [WAIT_W-1:0]     wait_q;
  logic [BURST_W-1:0]    burst_q;
  logic                  lock_q;
  logic                  last_cpu_q;
  logic                  we_q;
  logic                  cpu_ack_q;
  logic                  dma_ack_q;
  logic [DATA_WIDTH-1:0] cpu_rdata_q;
  logic [DATA_WIDTH-1:0] dma_rdata_q;
  logic                  mem_en_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic                  grant_cpu_d;
  logic                  any_req;

  assign any_req = bus.cpu_req | bus.dma_req;

  // Grantee for the next arbitration point; a saturated locked burst yields one CPU slot
  always_comb begin
    grant_cpu_d = bus.cpu_req;
    if (bus.cpu_req && bus.dma_req) begin
      if (lock_q) begin
        grant_cpu_d = (burst_q == BURST_W'(MAX_BURST));
      end else begin
`ifdef ARB_ROUND_ROBIN_EN
        grant_cpu_d = ~last_cpu_q;
`else
        grant_cpu_d = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      wait_q      <= '0;
      burst_q     <= '0;
      lock_q      <= 1'b0;
      last_cpu_q  <= 1'b0;
      we_q        <= 1'b0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_en_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      cpu_ack_q <= 1'b0;
      dma_ack_q <= 1'b0;
      case (state_q)
        // DONE arbitrates like IDLE so back-to-back requests lose no cycle
        S_IDLE, S_DONE: begin
          state_q <= S_IDLE;
          if (!bus.dma_req) begin
            lock_q  <= 1'b0;
            burst_q <= '0;
          end
          if (any_req) begin
            state_q    <= S_ACCESS;
            mem_en_q   <= 1'b1;
            last_cpu_q <= grant_cpu_d;
            if (grant_cpu_d) begin
              we_q        <= bus.cpu_we;
              mem_we_q    <= bus.cpu_we;
              mem_addr_q  <= bus.cpu_addr;
              mem_wdata_q <= bus.cpu_wdata;
              burst_q     <= '0;
            end else begin
              we_q        <= bus.dma_we;
              mem_we_q    <= bus.dma_we;
              mem_addr_q  <= bus.dma_addr;
              mem_wdata_q <= bus.dma_wdata;
              if (bus.dma_lock) begin
                lock_q <= 1'b1;
                if (burst_q != BURST_W'(MAX_BURST)) burst_q <= burst_q + BURST_W'(1);
              end else begin
                lock_q  <= 1'b0;
                burst_q <= '0;
              end
            end
          end
        end
        S_ACCESS: begin
          state_q <= S_WAIT;
          wait_q  <= WAIT_W'(MEM_LATENCY - 1);
        end
        S_WAIT: begin
          if (wait_q == '0) begin
            state_q <= S_DONE;
            if (last_cpu_q) begin
              cpu_ack_q <= 1'b1;
              if (!we_q) cpu_rdata_q <= bus.mem_rdata;
            end else begin
              dma_ack_q <= 1'b1;
              if (!we_q) dma_rdata_q <= bus.mem_rdata;
            end
          end else begin
            wait_q <= wait_q - WAIT_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.dma_ack   = dma_ack_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dma_rdata = dma_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.cpu_stall = bus.cpu_req & ~(last_cpu_q & (state_q != S_IDLE));

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, cycle-exact corner sequences,
// and queued CPU/DMA traffic checked against a transaction-level arbitration model.
module tb_mem_arbiter;

  localparam int unsigned LAT  = 1;
  localparam int unsigned MAXB = 256;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        lock;
  } op_t;

  typedef struct packed {
    logic       cpu;
    logic [7:0] crd;
    logic [7:0] drd;
  } ev_t;

  typedef struct {
    bit          dma;
    bit          we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_crd;
    logic [7:0]  exp_drd;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) b1 ();
  mem_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) b4 ();

  mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .MEM_LATENCY(LAT), .MAX_BURST(MAXB)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(b1.master));
  mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .MEM_LATENCY(4), .MAX_BURST(MAXB)) dut4 (
    .clk(clk), .reset_n(reset_n), .bus(b4.master));

  function automatic logic [7:0] pre_val(input logic [15:0] a);
    if (a == 16'h0010) return 8'hA5;
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Memory devices: latency-1 synchronous RAM and a latency-4 read pipeline
  logic [7:0] mem1 [int];
  logic [7:0] rd1 = '0;
  always @(posedge clk) begin
    if (b1.mem_en) begin
      if (b1.mem_we) mem1[int'(b1.mem_addr)] = b1.mem_wdata;
      else rd1 <= mem1.exists(int'(b1.mem_addr)) ? mem1[int'(b1.mem_addr)] : pre_val(b1.mem_addr);
    end
  end
  assign b1.mem_rdata = rd1;

  logic [7:0] p4 [4];
  always @(posedge clk) begin
    if (b4.mem_en && !b4.mem_we) p4[0] <= pre_val(b4.mem_addr);
    for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
  end
  assign b4.mem_rdata = p4[3];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor, sampled on the falling edge away from input changes
  ev_t  logq[$];
  int   stall_free = 0;
  int   viol = 0;
  logic prev_en = 1'b0;
  always @(negedge clk) begin
    if (b1.cpu_ack) logq.push_back('{1'b1, b1.cpu_rdata, b1.dma_rdata});
    if (b1.dma_ack) logq.push_back('{1'b0, b1.cpu_rdata, b1.dma_rdata});
    if (b1.cpu_req && !b1.cpu_stall) stall_free++;
    if ((b1.mem_we && !b1.mem_en) || (b1.mem_en && prev_en)) viol++;
    prev_en = b1.mem_en;
  end

  // Reference model state: memory image, per-port read data, last grantee
  logic [7:0] refmem [int];
  logic [7:0] m_crd = '0;
  logic [7:0] m_drd = '0;
  bit         m_last_cpu = 1'b0;
  op_t        cq[$];
  op_t        dq[$];
  ev_t        expq[$];

  function automatic logic [7:0] ref_rd(input logic [15:0] a);
    return refmem.exists(int'(a)) ? refmem[int'(a)] : pre_val(a);
  endfunction

  task automatic apply(input bit cpu, input op_t op);
    if (op.we) refmem[int'(op.addr)] = op.wdata;
    else if (cpu) m_crd = ref_rd(op.addr);
    else m_drd = ref_rd(op.addr);
    m_last_cpu = cpu;
  endtask

  function automatic bit tie_to_cpu();
`ifdef ARB_ROUND_ROBIN_EN
    return !m_last_cpu;
`else
    return 1'b0;
`endif
  endfunction

  // Predicts grant order and read data when both requesters stay busy until their queues drain
  task automatic model_run();
    int ci = 0, di = 0, burst = 0;
    bit lock = 1'b0, pick, cp, dp;
    op_t op;
    expq.delete();
    while (ci < cq.size() || di < dq.size()) begin
      cp = (ci < cq.size());
      dp = (di < dq.size());
      if (!dp) begin lock = 1'b0; burst = 0; end
      if (cp && dp) pick = lock ? (burst == int'(MAXB)) : tie_to_cpu();
      else pick = cp;
      if (pick) begin
        op = cq[ci]; ci++; burst = 0;
      end else begin
        op = dq[di]; di++;
        if (op.lock) begin lock = 1'b1; if (burst < int'(MAXB)) burst++; end
        else begin lock = 1'b0; burst = 0; end
      end
      apply(pick, op);
      expq.push_back('{pick, m_crd, m_drd});
    end
  endtask

  task automatic drive(input bit cpu);
    int n, guard;
    op_t op;
    n = cpu ? cq.size() : dq.size();
    for (int i = 0; i < n; i++) begin
      op = cpu ? cq[i] : dq[i];
      if (cpu) begin
        b1.cpu_we = op.we; b1.cpu_addr = op.addr; b1.cpu_wdata = op.wdata; b1.cpu_req = 1'b1;
      end else begin
        b1.dma_we = op.we; b1.dma_addr = op.addr; b1.dma_wdata = op.wdata;
        b1.dma_lock = op.lock; b1.dma_req = 1'b1;
      end
      guard = 0;
      do begin @(posedge clk); #1; guard++; end
      while (!(cpu ? b1.cpu_ack : b1.dma_ack) && guard < 3000);
      if (!(cpu ? b1.cpu_ack : b1.dma_ack)) begin
        check(cpu ? "cpu ack timeout" : "dma ack timeout", 32'(guard), 32'(0));
        break;
      end
    end
    if (cpu) b1.cpu_req = 1'b0;
    else begin b1.dma_req = 1'b0; b1.dma_lock = 1'b0; end
  endtask

  task automatic run_scenario(input string name);
    int base, sbase, vbase, nc, exp_free;
    base = logq.size(); sbase = stall_free; vbase = viol; nc = cq.size();
    model_run();
    fork
      drive(1'b1);
      drive(1'b0);
    join
    @(negedge clk); #1;
    check($sformatf("%s count", name), 32'(logq.size() - base), 32'(expq.size()));
    for (int i = 0; i < expq.size() && base + i < logq.size(); i++)
      check($sformatf("%s ev%0d", name, i), 32'(logq[base+i]), 32'(expq[i]));
    exp_free = (nc > 0) ? int'(2 + LAT) * nc - 1 : 0;
    check($sformatf("%s stall", name), 32'(stall_free - sbase), 32'(exp_free));
    check($sformatf("%s mem_en/we", name), 32'(viol - vbase), 32'(0));
    @(posedge clk); #1;
  endtask

  task automatic do_single(input bit dma, input bit we, input logic [15:0] addr,
                           input logic [7:0] wd, output int lat);
    op_t op;
    op = '{we, addr, wd, 1'b0};
    if (dma) begin
      b1.dma_we = we; b1.dma_addr = addr; b1.dma_wdata = wd; b1.dma_lock = 1'b0; b1.dma_req = 1'b1;
    end else begin
      b1.cpu_we = we; b1.cpu_addr = addr; b1.cpu_wdata = wd; b1.cpu_req = 1'b1;
    end
    lat = 0;
    do begin @(posedge clk); #1; lat++; end
    while (!(dma ? b1.dma_ack : b1.cpu_ack) && lat < 50);
    b1.cpu_req = 1'b0;
    b1.dma_req = 1'b0;
    apply(!dma, op);
  endtask

  function automatic op_t rnd_op(input logic [15:0] base, input int span);
    op_t op;
    op.we    = 1'($urandom_range(0, 1));
    op.addr  = base + 16'($urandom_range(0, span - 1));
    op.wdata = 8'($urandom);
    op.lock  = ($urandom_range(0, 3) != 0);
    return op;
  endfunction

  initial begin
    vec_t vecs[7];
    int lat;
    logic [7:0] en_bits, ack_bits;
    logic seen_ack;

    vecs[0] = '{1'b1, 1'b1, 16'h0200, 8'h3C, 8'h00, 8'h00};
    vecs[1] = '{1'b0, 1'b0, 16'h0200, 8'h00, 8'h3C, 8'h00};
    vecs[2] = '{1'b0, 1'b0, 16'h0010, 8'h00, 8'hA5, 8'h00};
    vecs[3] = '{1'b0, 1'b1, 16'h1234, 8'h77, 8'hA5, 8'h00};
    vecs[4] = '{1'b1, 1'b0, 16'h1234, 8'h00, 8'hA5, 8'h77};
    vecs[5] = '{1'b1, 1'b0, 16'hFFFF, 8'h00, 8'hA5, 8'h5A};
    vecs[6] = '{1'b0, 1'b0, 16'h0301, 8'h00, 8'h58, 8'h5A};

    b1.cpu_req = 0; b1.cpu_we = 0; b1.cpu_addr = '0; b1.cpu_wdata = '0;
    b1.dma_req = 0; b1.dma_we = 0; b1.dma_addr = '0; b1.dma_wdata = '0; b1.dma_lock = 0;
    b4.cpu_req = 0; b4.cpu_we = 0; b4.cpu_addr = '0; b4.cpu_wdata = '0;
    b4.dma_req = 0; b4.dma_we = 0; b4.dma_addr = '0; b4.dma_wdata = '0; b4.dma_lock = 0;

    #2 reset_n = 1'b0;
    #1;
    check("rst cpu_ack",   32'(b1.cpu_ack),   0);
    check("rst dma_ack",   32'(b1.dma_ack),   0);
    check("rst mem_en",    32'(b1.mem_en),    0);
    check("rst mem_we",    32'(b1.mem_we),    0);
    check("rst mem_addr",  32'(b1.mem_addr),  0);
    check("rst mem_wdata", 32'(b1.mem_wdata), 0);
    check("rst cpu_rdata", 32'(b1.cpu_rdata), 0);
    check("rst dma_rdata", 32'(b1.dma_rdata), 0);
    check("rst cpu_stall", 32'(b1.cpu_stall), 0);
    check("rst mem_en lat4", 32'(b4.mem_en),  0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    // Directed single transactions from the table
    for (int i = 0; i < 7; i++) begin
      do_single(vecs[i].dma, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(2 + LAT));
      check($sformatf("vec%0d cpu_rdata", i), 32'(b1.cpu_rdata), 32'(vecs[i].exp_crd));
      check($sformatf("vec%0d dma_rdata", i), 32'(b1.dma_rdata), 32'(vecs[i].exp_drd));
    end
    @(posedge clk); #1;

    // Simultaneous unlocked requests, 4 each
    cq.delete(); dq.delete();
    for (int i = 0; i < 4; i++) begin
      cq.push_back('{1'b0, 16'h0300 + 16'(i), 8'h00, 1'b0});
      dq.push_back('{1'b0, 16'h0310 + 16'(i), 8'h00, 1'b0});
    end
    run_scenario("tie");

    // Locked DMA burst longer than MAX_BURST with CPU waiting
    cq.delete(); dq.delete();
    cq.push_back('{1'b0, 16'h0500, 8'h00, 1'b0});
    cq.push_back('{1'b0, 16'h0501, 8'h00, 1'b0});
    for (int i = 0; i < 300; i++) begin
      dq.push_back(rnd_op(16'h0500, 16));
      dq[i].lock = 1'b1;
    end
    run_scenario("burst");

    // Randomized mixed traffic with hazards on a small address window
    for (int r = 0; r < 6; r++) begin
      cq.delete(); dq.delete();
      for (int i = 0; i < int'($urandom_range(0, 12)); i++) cq.push_back(rnd_op(16'h0400, 8));
      for (int i = 0; i < int'($urandom_range(0, 12)); i++) dq.push_back(rnd_op(16'h0400, 8));
      run_scenario($sformatf("rand%0d", r));
    end

    // Latency-4 CPU read: one mem_en cycle, ack five edges after it
    en_bits = '0; ack_bits = '0;
    b4.cpu_we = 1'b0; b4.cpu_addr = 16'h0010; b4.cpu_req = 1'b1;
    for (int c = 1; c < 8; c++) begin
      @(posedge clk); #1;
      en_bits[c]  = b4.mem_en;
      ack_bits[c] = b4.cpu_ack;
      if (b4.cpu_ack) begin
        check("lat4 cpu_rdata", 32'(b4.cpu_rdata), 32'h0000_00A5);
        b4.cpu_req = 1'b0;
      end
    end
    b4.cpu_req = 1'b0;
    check("lat4 mem_en pattern", 32'(en_bits), 32'h0000_0002);
    check("lat4 ack pattern", 32'(ack_bits), 32'h0000_0040);

    // Reset during WAIT aborts the CPU read with no ack
    b1.cpu_we = 1'b0; b1.cpu_addr = 16'h0010; b1.cpu_req = 1'b1;
    @(posedge clk); #1;
    check("abort mem_en", 32'(b1.mem_en), 1);
    @(posedge clk); #1;
    reset_n = 1'b0; b1.cpu_req = 1'b0;
    #1;
    check("abort mem_en rst", 32'(b1.mem_en), 0);
    check("abort cpu_ack rst", 32'(b1.cpu_ack), 0);
    check("abort cpu_rdata rst", 32'(b1.cpu_rdata), 0);
    check("abort mem_addr rst", 32'(b1.mem_addr), 0);
    check("abort cpu_stall rst", 32'(b1.cpu_stall), 0);
    m_crd = '0; m_drd = '0; m_last_cpu = 1'b0;
    #2 reset_n = 1'b1;
    seen_ack = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      seen_ack = seen_ack | b1.cpu_ack | b1.dma_ack;
    end
    check("abort no ack", 32'(seen_ack), 0);
    do_single(1'b0, 1'b0, 16'h0200, 8'h00, lat);
    check("post-reset latency", 32'(lat), 32'(2 + LAT));
    check("post-reset cpu_rdata", 32'(b1.cpu_rdata), 32'h0000_003C);
    check("post-reset dma_rdata", 32'(b1.dma_rdata), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
